// File: rtl/apb_rr_pkg.sv
// rtl/apb_rr_pkg.sv - shared types and bus widths for the APB round-robin master
package apb_rr_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - combinational round-robin picker, search starts just after the pointer
module apb_rr_arbiter
  import apb_rr_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  // Walk ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the last winner is visited last,
  // which gives it the lowest priority on the next decision.
  always_comb begin
    int k;
    k     = 0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(ptr_i) + i) % NUM_REQ;
      if (!any_o && req_i[IW'(k)]) begin
        any_o = 1'b1;
        idx_o = IW'(k);
      end
    end
    gnt_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/apb_rr_master.sv
// rtl/apb_rr_master.sv - APB3 master shared by NUM_REQ requesters; APB_TIMEOUT_EN adds an ACCESS timeout
module apb_rr_master
  import apb_rr_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*APB_AW-1:0] req_addr_i,
  input  logic [NUM_REQ*APB_DW-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [APB_DW-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_AW-1:0]         paddr_o,
  output logic [APB_DW-1:0]         pwdata_o,
  input  logic [APB_DW-1:0]         prdata_i,
  input  logic                      pready_i
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("apb_rr_master: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  apb_state_t          state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       gnt_idx_q, gnt_idx_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [APB_AW-1:0]   paddr_q, paddr_d;
  logic [APB_DW-1:0]   pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [APB_DW-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic                rsp_err_q, rsp_err_d;
`endif

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arbiter (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Acceptance is only offered while idle; the capture happens on the same edge.
  assign req_ready_o = (state_q == IDLE && !preset) ? arb_gnt : '0;

  // Next-state, bus drive and response computation. The bus outputs are
  // registered, so SETUP values are loaded on the accepting edge.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d   = SETUP;
          rr_ptr_d  = arb_idx;
          gnt_idx_d = arb_idx;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = req_write_i[arb_idx];
          paddr_d   = req_addr_i[int'(arb_idx)*APB_AW +: APB_AW];
          pwdata_d  = req_wdata_i[int'(arb_idx)*APB_DW +: APB_DW];
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (pready_i) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << gnt_idx_q;
          rsp_rdata_d = pwrite_q ? '0 : prdata_i;
`ifdef APB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << gnt_idx_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          wait_cnt_d  = wait_cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without a response.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IW'(NUM_REQ - 1);
      gnt_idx_q   <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_rr_master.sv
// tb/tb_apb_rr_master.sv - self-checking bench for apb_rr_master (APB_TIMEOUT_EN adds the timeout scenario)
module tb_apb_rr_master;

  localparam int N  = 4;
  localparam int TO = 16;

  logic            pclk = 1'b0;
  logic            preset;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N-1:0]    req_write_i;
  logic [N*32-1:0] req_addr_i;
  logic [N*32-1:0] req_wdata_i;
  logic [N-1:0]    rsp_valid_o;
  logic [31:0]     rsp_rdata_o;
  logic            rsp_err_o;
  logic            psel_o, penable_o, pwrite_o;
  logic [31:0]     paddr_o, pwdata_o, prdata_i;
  logic            pready_i;

  int checks = 0;
  int errors = 0;

  int          slave_waits = 0;
  logic [31:0] slave_mem [logic [31:0]];

  apb_rr_master #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .paddr_o     (paddr_o),
    .pwdata_o    (pwdata_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i)
  );

  always #5 pclk = ~pclk;

  function automatic logic [31:0] dflt_rd(logic [31:0] a);
    return a ^ 32'h5EED_0F0F;
  endfunction

  // Memory-backed slave: inserts slave_waits low cycles, then completes.
  initial begin
    int wcnt;
    wcnt     = 0;
    pready_i = 1'b0;
    prdata_i = '0;
    forever begin
      @(negedge pclk);
      if (psel_o && penable_o) begin
        if (wcnt >= slave_waits) begin
          pready_i = 1'b1;
          wcnt     = 0;
          if (pwrite_o) begin
            slave_mem[paddr_o] = pwdata_o;
            prdata_i = $urandom;
          end else begin
            prdata_i = slave_mem.exists(paddr_o) ? slave_mem[paddr_o] : dflt_rd(paddr_o);
          end
        end else begin
          pready_i = 1'b0;
          wcnt++;
        end
      end else begin
        pready_i = 1'b0;
        wcnt     = 0;
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(int k, bit wr, logic [31:0] a, logic [31:0] d);
    req_valid_i[k]         = 1'b1;
    req_write_i[k]         = wr;
    req_addr_i[k*32 +: 32] = a;
    req_wdata_i[k*32 +: 32] = d;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 32'hA000 + 32'(4*k), 32'h1111_0000 + 32'(k));
    step();
    step();
    @(negedge pclk);
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b rsp=%b err=%b rdata=%h psel=%b pen=%b pwr=%b addr=%h wdata=%h required all 0",
               req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o);
    end
    step();
    req_valid_i = '0;
    preset      = 1'b0;
    @(negedge pclk);
    checks++;
    if ({req_ready_o, psel_o, penable_o} !== '0) begin
      errors++;
      $display("FAIL reset_release_idle got ready=%b psel=%b pen=%b required 0", req_ready_o, psel_o, penable_o);
    end
  endtask

  task automatic test_single_write();
    step();
    slave_waits = 0;
    set_req(0, 1'b1, 32'hA000, 32'hDEAD_BEEF);
    @(negedge pclk);
    checks++;
    if (req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL wr_accept got %b required 0001", req_ready_o);
    end
    step();
    req_valid_i[0] = 1'b0;
    @(negedge pclk);
    checks++;
    if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o} !== {3'b101, 32'hA000, 32'hDEAD_BEEF, 4'b0000}) begin
      errors++;
      $display("FAIL wr_setup got psel=%b pen=%b pwr=%b addr=%h wdata=%h rsp=%b required 1 0 1 0000a000 deadbeef 0000",
               psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o);
    end
    step();
    @(negedge pclk);
    checks++;
    if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o} !== {3'b111, 32'hA000, 32'hDEAD_BEEF, 4'b0000}) begin
      errors++;
      $display("FAIL wr_access got psel=%b pen=%b pwr=%b addr=%h wdata=%h rsp=%b required 1 1 1 0000a000 deadbeef 0000",
               psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o);
    end
    step();
    @(negedge pclk);
    checks++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o, paddr_o} !== {4'b0001, 1'b0, 32'h0, 2'b00, 32'hA000}) begin
      errors++;
      $display("FAIL wr_rsp got rsp=%b err=%b rdata=%h psel=%b pen=%b addr=%h required 0001 0 0 0 0 0000a000",
               rsp_valid_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o, paddr_o);
    end
    step();
    @(negedge pclk);
    checks++;
    if (rsp_valid_o !== 4'b0000) begin
      errors++;
      $display("FAIL wr_rsp_pulse got %b required 0000", rsp_valid_o);
    end
  endtask

  task automatic test_read_back();
    step();
    slave_waits = 0;
    set_req(0, 1'b0, 32'hA000, 32'h0);
    @(negedge pclk);
    checks++;
    if (req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL rd_accept got %b required 0001", req_ready_o);
    end
    step();
    req_valid_i[0] = 1'b0;
    step();
    step();
    @(negedge pclk);
    checks++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {4'b0001, 1'b0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL rd_rsp got rsp=%b err=%b rdata=%h required 0001 0 deadbeef", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    step();
    slave_waits = 1000;
    set_req(1, 1'b0, 32'hA004, 32'h0);
    @(negedge pclk);
    checks++;
    if (req_ready_o !== 4'b0010) begin
      errors++;
      $display("FAIL to_accept got %b required 0010", req_ready_o);
    end
    step();
    req_valid_i[1] = 1'b0;
    for (int c = 0; c < TO; c++) begin
      step();
      @(negedge pclk);
      checks++;
      if ({psel_o, penable_o, rsp_valid_o} !== {2'b11, 4'b0000}) begin
        errors++;
        $display("FAIL to_access_%0d got psel=%b pen=%b rsp=%b required 1 1 0000", c, psel_o, penable_o, rsp_valid_o);
      end
    end
    step();
    @(negedge pclk);
    checks++;
    if ({psel_o, penable_o, rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b00, 4'b0010, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL to_rsp got psel=%b pen=%b rsp=%b err=%b rdata=%h required 0 0 0010 1 0",
               psel_o, penable_o, rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    slave_waits = 0;
  endtask
`endif

  task automatic test_wait_states();
    logic [31:0] d;
    d = $urandom;
    step();
    slave_waits = 5;
    set_req(2, 1'b1, 32'hA008, d);
    @(negedge pclk);
    checks++;
    if (req_ready_o !== 4'b0100) begin
      errors++;
      $display("FAIL ws_accept got %b required 0100", req_ready_o);
    end
    step();
    req_valid_i[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      @(negedge pclk);
      checks++;
      if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o} !== {3'b111, 32'hA008, d, 4'b0000}) begin
        errors++;
        $display("FAIL ws_hold_%0d got psel=%b pen=%b pwr=%b addr=%h wdata=%h rsp=%b required 1 1 1 0000a008 %h 0000",
                 c, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o, d);
      end
    end
    step();
    @(negedge pclk);
    checks++;
    if ({rsp_valid_o, rsp_err_o, psel_o} !== {4'b0100, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ws_rsp got rsp=%b err=%b psel=%b required 0100 0 0", rsp_valid_o, rsp_err_o, psel_o);
    end
    slave_waits = 0;
  endtask

  task automatic test_contention();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    int n;
    n = 0;
    step();
    slave_waits = 0;
    preset = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 32'hA010 + 32'(4*k), 32'(k));
    step();
    step();
    preset = 1'b0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      @(negedge pclk);
      if (req_ready_o !== 4'b0000) begin
        checks++;
        if ({req_ready_o, psel_o} !== {4'(1 << exp_seq[n]), 1'b0}) begin
          errors++;
          $display("FAIL cont_grant_%0d got ready=%b psel=%b required %b 0", n, req_ready_o, psel_o, 4'(1 << exp_seq[n]));
        end
        n++;
      end
      step();
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL cont_timeout got %0d grants required 5", n);
    end
    req_valid_i = '0;
    repeat (6) step();
  endtask

  task automatic test_reset_mid();
    int n0, nbad;
    n0   = 0;
    nbad = 0;
    step();
    slave_waits = 10;
    set_req(1, 1'b1, 32'hA00C, $urandom);
    @(negedge pclk);
    checks++;
    if (req_ready_o !== 4'b0010) begin
      errors++;
      $display("FAIL rst_accept got %b required 0010", req_ready_o);
    end
    step();
    req_valid_i[1] = 1'b0;
    step();
    @(negedge pclk);
    checks++;
    if ({psel_o, penable_o} !== 2'b11) begin
      errors++;
      $display("FAIL rst_in_access got psel=%b pen=%b required 1 1", psel_o, penable_o);
    end
    step();
    preset = 1'b1;
    set_req(0, 1'b1, 32'hA020, 32'h0000_00AA);
    set_req(2, 1'b1, 32'hA024, 32'h0000_00BB);
    step();
    preset = 1'b0;
    @(negedge pclk);
    checks++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, req_ready_o} !== {4'b0000, 1'b0, 32'h0, 3'b000, 64'h0, 4'b0001}) begin
      errors++;
      $display("FAIL rst_abort got rsp=%b err=%b rdata=%h psel=%b pen=%b pwr=%b addr=%h wdata=%h ready=%b required zeros and ready 0001",
               rsp_valid_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, req_ready_o);
    end
    slave_waits = 0;
    step();
    req_valid_i = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge pclk);
      if (rsp_valid_o === 4'b0001) n0++;
      else if (rsp_valid_o !== 4'b0000) nbad++;
      step();
    end
    checks++;
    if (n0 != 1 || nbad != 0) begin
      errors++;
      $display("FAIL rst_after got req0_rsps=%0d other_rsps=%0d required 1 0", n0, nbad);
    end
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [logic [31:0]];
    bit          busy;
    int          ptr, cyc, acc_cyc, lat, idx, nxt, d;
    bit          found, exp_wr;
    logic [31:0] exp_a, exp_d, exp_rd;
    logic [N-1:0] acc_last, exp_rdy;
    busy     = 1'b0;
    ptr      = N - 1;
    cyc      = 0;
    acc_cyc  = 0;
    lat      = 0;
    idx      = 0;
    exp_wr   = 1'b0;
    exp_a    = '0;
    exp_d    = '0;
    acc_last = '0;
    slave_mem.delete();
    step();
    req_valid_i = '0;
    preset      = 1'b1;
    step();
    step();
    preset = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (acc_last[k]) req_valid_i[k] = 1'b0;
        else if (!req_valid_i[k] && $urandom_range(0, 2) == 0)
          set_req(k, 1'($urandom_range(0, 1)), 32'hA000 + 32'(4 * $urandom_range(0, 7)), $urandom);
      end
      acc_last = '0;
      @(negedge pclk);
      if (busy && cyc == acc_cyc + lat) begin
        exp_rd = exp_wr ? 32'h0 : (ref_mem.exists(exp_a) ? ref_mem[exp_a] : dflt_rd(exp_a));
        checks++;
        if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o} !== {4'(1 << idx), 1'b0, exp_rd, 2'b00}) begin
          errors++;
          $display("FAIL rnd_rsp cyc=%0d got rsp=%b err=%b rdata=%h psel=%b pen=%b required %b 0 %h 0 0",
                   cyc, rsp_valid_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o, 4'(1 << idx), exp_rd);
        end
        if (exp_wr) ref_mem[exp_a] = exp_d;
        busy = 1'b0;
      end else begin
        checks++;
        if (rsp_valid_o !== 4'b0000) begin
          errors++;
          $display("FAIL rnd_no_rsp cyc=%0d got %b required 0000", cyc, rsp_valid_o);
        end
      end
      if (busy) begin
        d = cyc - acc_cyc;
        checks++;
        if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o} !== {1'b1, (d > 1), exp_wr, exp_a, exp_d}) begin
          errors++;
          $display("FAIL rnd_bus cyc=%0d phase=%0d got psel=%b pen=%b pwr=%b addr=%h wdata=%h required 1 %b %b %h %h",
                   cyc, d, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, (d > 1), exp_wr, exp_a, exp_d);
        end
      end else begin
        checks++;
        if ({psel_o, penable_o} !== 2'b00) begin
          errors++;
          $display("FAIL rnd_idle_bus cyc=%0d got psel=%b pen=%b required 0 0", cyc, psel_o, penable_o);
        end
      end
      exp_rdy = '0;
      found   = 1'b0;
      nxt     = 0;
      if (!busy) begin
        for (int i = 1; i <= N; i++) begin
          if (!found && req_valid_i[(ptr + i) % N]) begin
            found = 1'b1;
            nxt   = (ptr + i) % N;
          end
        end
        if (found) exp_rdy[nxt] = 1'b1;
      end
      checks++;
      if (req_ready_o !== exp_rdy) begin
        errors++;
        $display("FAIL rnd_grant cyc=%0d got %b required %b", cyc, req_ready_o, exp_rdy);
      end
      if (found) begin
        busy          = 1'b1;
        acc_cyc       = cyc;
        idx           = nxt;
        ptr           = nxt;
        exp_wr        = req_write_i[nxt];
        exp_a         = req_addr_i[nxt*32 +: 32];
        exp_d         = req_wdata_i[nxt*32 +: 32];
        slave_waits   = $urandom_range(0, 3);
        lat           = 3 + slave_waits;
        acc_last[nxt] = 1'b1;
      end
      cyc++;
      step();
    end
    req_valid_i = '0;
    repeat (10) step();
  endtask

  initial begin
    preset      = 1'b1;
    req_valid_i = '0;
    req_write_i = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    test_reset();
    test_single_write();
    test_read_back();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    test_wait_states();
    test_contention();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
